// File: rtl/rv32i_core_if.sv
// Data-memory bus between the rv32i_core datapath and its internal data memory.
// The datapath drives address, write data and byte strobes; the memory returns the addressed word.
interface rv32i_core_if;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        we;
  logic [31:0] rdata;

  modport master (output addr, output wdata, output wstrb, output we, input rdata);
  modport slave  (input addr, input wdata, input wstrb, input we, output rdata);
endinterface

// File: rtl/rv32i_core.sv
// Single-cycle RV32I core: combinational fetch/decode/execute, all state commits on one posedge.
// Instance and array names under data_path_inst are used by external loaders and checkers.

module rv32i_imem #(
  parameter int unsigned IMEM_DEPTH = 256
) (
  input  logic                          clk,
  input  logic                          we,
  input  logic [$clog2(IMEM_DEPTH)-1:0] waddr,
  input  logic [31:0]                   wdata,
  input  logic [$clog2(IMEM_DEPTH)-1:0] raddr,
  output logic [31:0]                   rdata
);
  logic [31:0] imem [IMEM_DEPTH];

  assign rdata = imem[raddr];

  // Loader write port; the core itself never writes instruction memory.
  always_ff @(posedge clk) begin
    if (we) imem[waddr] <= wdata;
  end
endmodule

module rv32i_reg_file (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [4:0]  raddr1,
  input  logic [4:0]  raddr2,
  input  logic [4:0]  waddr,
  input  logic        we,
  input  logic [31:0] wdata,
  output logic [31:0] rdata1,
  output logic [31:0] rdata2
);
  logic [31:0] reg_file [32];

  assign rdata1 = (raddr1 == 5'd0) ? 32'd0 : reg_file[raddr1];
  assign rdata2 = (raddr2 == 5'd0) ? 32'd0 : reg_file[raddr2];

  always_ff @(posedge clk) begin
    if (reset_n) begin
      reg_file <= '{default: '0};
    end else if (we && (waddr != 5'd0)) begin
      reg_file[waddr] <= wdata;
    end
  end
endmodule

module rv32i_dmem #(
  parameter int unsigned DMEM_DEPTH = 256
) (
  input logic         clk,
  rv32i_core_if.slave bus
);
  localparam int unsigned Aw = $clog2(DMEM_DEPTH);

  logic [31:0]   dmem [DMEM_DEPTH];
  logic [Aw-1:0] idx;
  logic          unused_addr;

  assign idx         = bus.addr[Aw+1:2];
  assign unused_addr = ^{bus.addr[31:Aw+2], bus.addr[1:0]};
  assign bus.rdata   = dmem[idx];

  always_ff @(posedge clk) begin
    if (bus.we) begin
      if (bus.wstrb[0]) dmem[idx][7:0]   <= bus.wdata[7:0];
      if (bus.wstrb[1]) dmem[idx][15:8]  <= bus.wdata[15:8];
      if (bus.wstrb[2]) dmem[idx][23:16] <= bus.wdata[23:16];
      if (bus.wstrb[3]) dmem[idx][31:24] <= bus.wdata[31:24];
    end
  end
endmodule

module rv32i_data_path #(
  parameter int unsigned IMEM_DEPTH = 256,
  parameter int unsigned DMEM_DEPTH = 256,
  parameter logic [31:0] RESET_PC   = 32'h0
) (
  input logic clk,
  input logic reset_n
);
  localparam int unsigned Iaw = $clog2(IMEM_DEPTH);

  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpReg    = 7'b0110011;

  logic [31:0] pc_q, pc_d, pc_plus4, instr;
  logic [6:0]  opcode;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [31:0] rs1_val, rs2_val, rd_wdata, mem_addr;
  logic [7:0]  load_byte;
  logic [15:0] load_half;
  logic        rd_we, store_en, branch_taken;

  rv32i_core_if dmem_bus ();

  function automatic logic [31:0] alu(input logic [2:0] f3, input logic alt,
                                      input logic [31:0] a, input logic [31:0] b);
    case (f3)
      3'b000:  alu = alt ? a - b : a + b;
      3'b001:  alu = a << b[4:0];
      3'b010:  alu = {31'b0, $signed(a) < $signed(b)};
      3'b011:  alu = {31'b0, a < b};
      3'b100:  alu = a ^ b;
      3'b101:  alu = alt ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
      3'b110:  alu = a | b;
      default: alu = a & b;
    endcase
  endfunction

  rv32i_imem #(.IMEM_DEPTH(IMEM_DEPTH)) imem_inst (
    .clk   (clk),
    .we    (1'b0),
    .waddr ('0),
    .wdata ('0),
    .raddr (pc_q[Iaw+1:2]),
    .rdata (instr)
  );

  rv32i_reg_file reg_file_inst (
    .clk     (clk),
    .reset_n (reset_n),
    .raddr1  (rs1),
    .raddr2  (rs2),
    .waddr   (rd),
    .we      (rd_we),
    .wdata   (rd_wdata),
    .rdata1  (rs1_val),
    .rdata2  (rs2_val)
  );

  rv32i_dmem #(.DMEM_DEPTH(DMEM_DEPTH)) dmem_inst (
    .clk (clk),
    .bus (dmem_bus)
  );

  assign opcode   = instr[6:0];
  assign rd       = instr[11:7];
  assign funct3   = instr[14:12];
  assign rs1      = instr[19:15];
  assign rs2      = instr[24:20];
  assign imm_i    = {{20{instr[31]}}, instr[31:20]};
  assign imm_s    = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b    = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u    = {instr[31:12], 12'b0};
  assign imm_j    = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
  assign pc_plus4 = pc_q + 32'd4;

  assign mem_addr       = rs1_val + ((opcode == OpStore) ? imm_s : imm_i);
  assign dmem_bus.addr  = mem_addr;
  // A reset edge must not retire the store sitting in the current instruction.
  assign dmem_bus.we    = store_en & ~reset_n;
  assign load_byte      = dmem_bus.rdata[{mem_addr[1:0], 3'b000} +: 8];
  assign load_half      = mem_addr[1] ? dmem_bus.rdata[31:16] : dmem_bus.rdata[15:0];

  always_comb begin
    case (funct3)
      3'b000:  branch_taken = (rs1_val == rs2_val);
      3'b001:  branch_taken = (rs1_val != rs2_val);
      3'b100:  branch_taken = ($signed(rs1_val) < $signed(rs2_val));
      3'b101:  branch_taken = ($signed(rs1_val) >= $signed(rs2_val));
      3'b110:  branch_taken = (rs1_val < rs2_val);
      3'b111:  branch_taken = (rs1_val >= rs2_val);
      default: branch_taken = 1'b0;
    endcase
  end

  always_comb begin
    case (funct3[1:0])
      2'b00: begin
        dmem_bus.wstrb = 4'b0001 << mem_addr[1:0];
        dmem_bus.wdata = {4{rs2_val[7:0]}};
      end
      2'b01: begin
        dmem_bus.wstrb = mem_addr[1] ? 4'b1100 : 4'b0011;
        dmem_bus.wdata = {2{rs2_val[15:0]}};
      end
      default: begin
        dmem_bus.wstrb = 4'b1111;
        dmem_bus.wdata = rs2_val;
      end
    endcase
  end

  // Unsupported opcodes and reserved funct3 values fall through as NOPs.
  always_comb begin
    pc_d     = pc_plus4;
    rd_we    = 1'b0;
    rd_wdata = 32'd0;
    store_en = 1'b0;
    case (opcode)
      OpLui: begin
        rd_we    = 1'b1;
        rd_wdata = imm_u;
      end
      OpAuipc: begin
        rd_we    = 1'b1;
        rd_wdata = pc_q + imm_u;
      end
      OpJal: begin
        rd_we    = 1'b1;
        rd_wdata = pc_plus4;
        pc_d     = pc_q + imm_j;
      end
      OpJalr: begin
        if (funct3 == 3'b000) begin
          rd_we    = 1'b1;
          rd_wdata = pc_plus4;
          pc_d     = (rs1_val + imm_i) & ~32'd1;
        end
      end
      OpBranch: begin
        if (branch_taken) pc_d = pc_q + imm_b;
      end
      OpLoad: begin
        rd_we = 1'b1;
        case (funct3)
          3'b000:  rd_wdata = {{24{load_byte[7]}}, load_byte};
          3'b001:  rd_wdata = {{16{load_half[15]}}, load_half};
          3'b010:  rd_wdata = dmem_bus.rdata;
          3'b100:  rd_wdata = {24'b0, load_byte};
          3'b101:  rd_wdata = {16'b0, load_half};
          default: rd_we    = 1'b0;
        endcase
      end
      OpStore: store_en = ~funct3[2] & (funct3[1:0] != 2'b11);
      OpImm: begin
        rd_we    = 1'b1;
        rd_wdata = alu(funct3, (funct3 == 3'b101) & instr[30], rs1_val, imm_i);
      end
      OpReg: begin
        rd_we    = 1'b1;
        rd_wdata = alu(funct3, instr[30], rs1_val, rs2_val);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset_n) pc_q <= RESET_PC;
    else         pc_q <= pc_d;
  end
endmodule

module rv32i_core #(
  parameter int unsigned IMEM_DEPTH = 256,
  parameter int unsigned DMEM_DEPTH = 256,
  parameter logic [31:0] RESET_PC   = 32'h0
) (
  input logic clk,
  input logic reset_n
);
  rv32i_data_path #(
    .IMEM_DEPTH (IMEM_DEPTH),
    .DMEM_DEPTH (DMEM_DEPTH),
    .RESET_PC   (RESET_PC)
  ) data_path_inst (
    .clk     (clk),
    .reset_n (reset_n)
  );
endmodule

// File: tb/tb_rv32i_core.sv
// Directed-program bench for rv32i_core: stimulus queues expected state, a monitor drains and compares.
module tb_rv32i_core;
  localparam int OpcLui = 'h37, OpcAuipc = 'h17, OpcJal = 'h6f, OpcJalr = 'h67;
  localparam int OpcBr = 'h63, OpcLd = 'h03, OpcSt = 'h23, OpcImm = 'h13, OpcReg = 'h33;
  localparam logic [31:0] Nop = 32'h0000_0013;

  localparam int KReg = 0, KPc = 1, KMem = 2;

  typedef struct {
    string       name;
    int          kind;
    logic [7:0]  idx;
    logic [31:0] exp;
  } exp_t;

  logic        clk;
  logic        reset_n;
  exp_t        exp_q[$];
  logic [31:0] prog[$];
  logic [31:0] gold [32];
  bit          chk_req;
  int          checks;
  int          failures;

  rv32i_core dut (
    .clk     (clk),
    .reset_n (reset_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] enc_i(int op, int rd, int f3, int rs1, int imm);
    logic [31:0] im = imm;
    return {im[11:0], 5'(rs1), 3'(f3), 5'(rd), 7'(op)};
  endfunction

  function automatic logic [31:0] enc_r(int f7, int rd, int f3, int rs1, int rs2);
    return {7'(f7), 5'(rs2), 5'(rs1), 3'(f3), 5'(rd), 7'(OpcReg)};
  endfunction

  function automatic logic [31:0] enc_s(int f3, int rs2, int rs1, int imm);
    logic [31:0] im = imm;
    return {im[11:5], 5'(rs2), 5'(rs1), 3'(f3), im[4:0], 7'(OpcSt)};
  endfunction

  function automatic logic [31:0] enc_b(int f3, int rs1, int rs2, int imm);
    logic [31:0] im = imm;
    return {im[12], im[10:5], 5'(rs2), 5'(rs1), 3'(f3), im[4:1], im[11], 7'(OpcBr)};
  endfunction

  function automatic logic [31:0] enc_u(int op, int rd, int imm20);
    logic [31:0] im = imm20;
    return {im[19:0], 5'(rd), 7'(op)};
  endfunction

  function automatic logic [31:0] enc_j(int rd, int imm);
    logic [31:0] im = imm;
    return {im[20], im[10:1], im[11], im[19:12], 5'(rd), 7'(OpcJal)};
  endfunction

  task automatic exp_reg(string name, int idx, logic [31:0] v);
    exp_q.push_back('{name, KReg, 8'(idx), v});
  endtask

  task automatic exp_pc(string name, logic [31:0] v);
    exp_q.push_back('{name, KPc, 8'd0, v});
  endtask

  task automatic exp_mem(string name, int idx, logic [31:0] v);
    exp_q.push_back('{name, KMem, 8'(idx), v});
  endtask

  task automatic load_imem();
    for (int i = 0; i < 256; i++) begin
      dut.data_path_inst.imem_inst.imem[8'(i)] = (i < prog.size()) ? prog[i] : Nop;
    end
    prog.delete();
  endtask

  // Reset for two edges with the new program in place, then release at a negedge.
  task automatic start_prog();
    reset_n = 1'b1;
    load_imem();
    repeat (2) @(negedge clk);
    reset_n = 1'b0;
  endtask

  task automatic check_now();
    chk_req = 1'b1;
    for (int t = 0; t < 4 && chk_req; t++) @(negedge clk);
    if (chk_req) begin
      checks++;
      failures++;
      $display("FAIL monitor_timeout: actual=%0d_pending required=0_pending", exp_q.size());
      exp_q.delete();
      chk_req = 1'b0;
    end
  endtask

  task automatic build_ctrl_prog();
    prog.push_back(enc_i(OpcImm, 7, 0, 0, 10));       // 0
    prog.push_back(enc_i(OpcImm, 1, 0, 1, 1));        // 4  loop
    prog.push_back(enc_b(1, 1, 7, -4));               // 8  bne x1,x7,-4
    prog.push_back(enc_j(5, 8));                      // 12 jal x5,+8
    prog.push_back(enc_i(OpcImm, 6, 0, 0, 99));       // 16 skipped
    prog.push_back(enc_i(OpcImm, 8, 0, 0, 1));        // 20
    prog.push_back(enc_i(OpcImm, 2, 0, 0, -1));       // 24
    prog.push_back(enc_b(4, 2, 0, 8));                // 28 blt taken
    prog.push_back(enc_i(OpcImm, 10, 0, 0, 1));       // 32 skipped
    prog.push_back(enc_b(6, 2, 0, 8));                // 36 bltu not taken
    prog.push_back(enc_i(OpcImm, 11, 0, 0, 1));       // 40
    prog.push_back(enc_b(7, 2, 7, 8));                // 44 bgeu taken
    prog.push_back(enc_i(OpcImm, 12, 0, 0, 1));       // 48 skipped
    prog.push_back(enc_b(5, 0, 2, 8));                // 52 bge taken
    prog.push_back(enc_i(OpcImm, 13, 0, 0, 1));       // 56 skipped
    prog.push_back(enc_b(0, 1, 7, 8));                // 60 beq taken
    prog.push_back(enc_i(OpcImm, 14, 0, 0, 1));       // 64 skipped
    prog.push_back(enc_u(OpcAuipc, 15, 1));           // 68
    prog.push_back(enc_i(OpcJalr, 16, 0, 5, 69));     // 72 -> (16+69)&~1 = 84
    prog.push_back(enc_i(OpcImm, 17, 0, 0, 1));       // 76 skipped
    prog.push_back(enc_i(OpcImm, 18, 0, 0, 1));       // 80 skipped
    prog.push_back(enc_i(OpcImm, 19, 0, 0, 1));       // 84
    prog.push_back(enc_j(0, 0));                      // 88 halt
  endtask

  initial begin : monitor
    exp_t        e;
    logic [31:0] act;
    forever begin
      @(negedge clk);
      #1;
      if (chk_req) begin
        while (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          case (e.kind)
            KReg:    act = dut.data_path_inst.reg_file_inst.reg_file[e.idx[4:0]];
            KPc:     act = dut.data_path_inst.pc_q;
            default: act = dut.data_path_inst.dmem_inst.dmem[e.idx];
          endcase
          checks++;
          if (act !== e.exp) begin
            failures++;
            $display("FAIL %s: actual=%08h required=%08h", e.name, act, e.exp);
          end
        end
        chk_req = 1'b0;
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    checks   = 0;
    failures = 0;
    chk_req  = 1'b0;
    reset_n  = 1'b1;

    // Reset with junk in every register, ALU program preloaded.
    prog.push_back(enc_i(OpcImm, 1, 0, 0, 5));
    prog.push_back(enc_i(OpcImm, 2, 0, 0, -3));
    prog.push_back(enc_r(0, 3, 0, 1, 2));             // add
    prog.push_back(enc_r('h20, 4, 0, 2, 1));          // sub x4,x2,x1
    prog.push_back(enc_r(0, 5, 3, 1, 2));             // sltu
    prog.push_back(enc_i(OpcImm, 6, 5, 2, 'h401));    // srai x6,x2,1
    prog.push_back(enc_r(0, 7, 2, 2, 1));             // slt x7,x2,x1
    prog.push_back(enc_i(OpcImm, 8, 4, 1, -1));       // xori
    prog.push_back(enc_i(OpcImm, 9, 5, 2, 28));       // srli
    prog.push_back(enc_r(0, 10, 1, 1, 1));            // sll x10,x1,x1
    prog.push_back(enc_r('h20, 11, 5, 2, 1));         // sra x11,x2,x1
    prog.push_back(enc_i(OpcImm, 12, 3, 1, -1));      // sltiu
    prog.push_back(enc_i(OpcImm, 13, 7, 2, 'hf0));    // andi
    prog.push_back(enc_i(OpcImm, 14, 6, 1, 'h100));   // ori
    prog.push_back(enc_i(OpcImm, 16, 0, 0, 33));
    prog.push_back(enc_r(0, 17, 1, 1, 16));           // sll by 33 -> by 1
    prog.push_back(enc_j(0, 0));
    load_imem();
    for (int i = 0; i < 32; i++) begin
      dut.data_path_inst.reg_file_inst.reg_file[5'(i)] = 32'hDEAD_0000 | 32'(i);
    end
    repeat (2) @(negedge clk);
    exp_pc("rst_pc", 32'h0);
    for (int i = 0; i < 32; i++) exp_reg($sformatf("rst_x%0d", i), i, 32'h0);
    check_now();

    reset_n = 1'b0;
    @(negedge clk);
    exp_pc("first_pc", 32'h4);
    exp_reg("first_x1", 1, 32'd5);
    check_now();

    repeat (30) @(negedge clk);
    exp_reg("alu_x2", 2, 32'hFFFF_FFFD);
    exp_reg("alu_add", 3, 32'd2);
    exp_reg("alu_sub", 4, 32'hFFFF_FFF8);
    exp_reg("alu_sltu", 5, 32'd1);
    exp_reg("alu_srai", 6, 32'hFFFF_FFFE);
    exp_reg("alu_slt", 7, 32'd1);
    exp_reg("alu_xori", 8, 32'hFFFF_FFFA);
    exp_reg("alu_srli", 9, 32'h0000_000F);
    exp_reg("alu_sll", 10, 32'h0000_00A0);
    exp_reg("alu_sra", 11, 32'hFFFF_FFFF);
    exp_reg("alu_sltiu", 12, 32'd1);
    exp_reg("alu_andi", 13, 32'h0000_00F0);
    exp_reg("alu_ori", 14, 32'h0000_0105);
    exp_reg("alu_shamt5", 17, 32'd10);
    check_now();

    // Loads and stores, including sub-word merge, sign handling and index wrap.
    dut.data_path_inst.dmem_inst.dmem[8'd1] = 32'hCAFE_F00D;
    dut.data_path_inst.dmem_inst.dmem[8'd3] = 32'hAAAA_AAAA;
    prog.push_back(enc_u(OpcLui, 1, 'h12345));
    prog.push_back(enc_i(OpcImm, 1, 0, 1, 'h678));
    prog.push_back(enc_s(2, 1, 0, 8));                // sw x1,8
    prog.push_back(enc_i(OpcLd, 2, 0, 0, 9));         // lb
    prog.push_back(enc_i(OpcLd, 3, 5, 0, 10));        // lhu
    prog.push_back(enc_i(OpcImm, 4, 0, 0, -128));
    prog.push_back(enc_s(0, 4, 0, 11));               // sb
    prog.push_back(enc_i(OpcLd, 5, 0, 0, 11));        // lb
    prog.push_back(enc_i(OpcLd, 6, 4, 0, 11));        // lbu
    prog.push_back(enc_s(1, 4, 0, 12));               // sh low half
    prog.push_back(enc_i(OpcLd, 7, 1, 0, 12));        // lh
    prog.push_back(enc_i(OpcLd, 8, 2, 0, 8));         // lw
    prog.push_back(enc_s(1, 4, 0, 14));               // sh high half
    prog.push_back(enc_i(OpcLd, 9, 5, 0, 14));        // lhu
    prog.push_back(enc_s(2, 1, 0, 1024));             // wraps to word 0
    prog.push_back(enc_i(OpcLd, 10, 2, 0, 5));        // misaligned lw
    prog.push_back(enc_j(0, 0));
    start_prog();
    repeat (30) @(negedge clk);
    exp_reg("mem_x1", 1, 32'h1234_5678);
    exp_reg("mem_lb", 2, 32'h0000_0056);
    exp_reg("mem_lhu", 3, 32'h0000_1234);
    exp_reg("mem_lb_neg", 5, 32'hFFFF_FF80);
    exp_reg("mem_lbu", 6, 32'h0000_0080);
    exp_reg("mem_lh", 7, 32'hFFFF_FF80);
    exp_reg("mem_lw", 8, 32'h8034_5678);
    exp_reg("mem_lhu_hi", 9, 32'h0000_FF80);
    exp_reg("mem_lw_misalign", 10, 32'hCAFE_F00D);
    exp_mem("mem_word2", 2, 32'h8034_5678);
    exp_mem("mem_word3", 3, 32'hFF80_FF80);
    exp_mem("mem_wrap", 0, 32'h1234_5678);
    check_now();

    // Control flow.
    build_ctrl_prog();
    start_prog();
    repeat (70) @(negedge clk);
    exp_pc("ctl_pc", 32'd88);
    exp_reg("ctl_loop", 1, 32'd10);
    exp_reg("ctl_jal_link", 5, 32'd16);
    exp_reg("ctl_jal_skip", 6, 32'd0);
    exp_reg("ctl_after_jal", 8, 32'd1);
    exp_reg("ctl_blt", 10, 32'd0);
    exp_reg("ctl_bltu", 11, 32'd1);
    exp_reg("ctl_bgeu", 12, 32'd0);
    exp_reg("ctl_bge", 13, 32'd0);
    exp_reg("ctl_beq", 14, 32'd0);
    exp_reg("ctl_auipc", 15, 32'h0000_1044);
    exp_reg("ctl_jalr_link", 16, 32'd76);
    exp_reg("ctl_jalr_skip", 18, 32'd0);
    exp_reg("ctl_jalr_tgt", 19, 32'd1);
    check_now();

    // x0 writes and unsupported encodings.
    prog.push_back(enc_i(OpcImm, 0, 0, 0, 7));
    prog.push_back(32'h0000_0073);                    // ecall
    prog.push_back(32'h0000_000F);                    // fence
    prog.push_back(32'hFFFF_FFFF);                    // unknown opcode
    prog.push_back(enc_i(OpcImm, 1, 0, 0, 3));
    prog.push_back(enc_j(0, 0));
    start_prog();
    repeat (4) @(negedge clk);
    exp_pc("nop_pc", 32'd16);
    exp_reg("nop_x0", 0, 32'd0);
    exp_reg("nop_x1_pending", 1, 32'd0);
    check_now();
    repeat (4) @(negedge clk);
    exp_pc("nop_halt_pc", 32'd20);
    exp_reg("nop_x1", 1, 32'd3);
    check_now();

    // Reset in the middle of the loop, then a long run to completion.
    build_ctrl_prog();
    start_prog();
    repeat (9) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    exp_pc("midrst_pc", 32'd0);
    exp_reg("midrst_x1", 1, 32'd0);
    exp_reg("midrst_x7", 7, 32'd0);
    check_now();
    reset_n = 1'b0;
    repeat (1000) @(negedge clk);
    for (int i = 0; i < 32; i++) gold[5'(i)] = 32'd0;
    gold[1]  = 32'd10;
    gold[2]  = 32'hFFFF_FFFF;
    gold[5]  = 32'd16;
    gold[7]  = 32'd10;
    gold[8]  = 32'd1;
    gold[11] = 32'd1;
    gold[15] = 32'h0000_1044;
    gold[16] = 32'd76;
    gold[19] = 32'd1;
    exp_pc("dump_pc", 32'd88);
    for (int i = 0; i < 32; i++) exp_reg($sformatf("dump_x%0d", i), i, gold[5'(i)]);
    check_now();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
